// File: rtl/jtag_scan_master.sv
// Host-side JTAG scan master: turns DR/IR/TAP-reset commands into TMS/TDI sequences
// and collects TDO into a response word. The TAP always returns to Run-Test/Idle.
module jtag_scan_master #(
  parameter int unsigned MAXW = 32,
  parameter int unsigned LENW = 6
) (
  input  logic            TCK,
  input  logic            TRST,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [LENW-1:0] cmd_len,
  input  logic [MAXW-1:0] cmd_data,
  output logic            TMS,
  output logic            TDI,
  input  logic            TDO,
  output logic            rsp_valid,
  output logic [MAXW-1:0] rsp_data,
  output logic            busy
);

  localparam int unsigned StepW = $clog2(MAXW + 8);
  localparam int unsigned IdxW  = (MAXW > 1) ? $clog2(MAXW) : 1;

  localparam logic [1:0] OpDr     = 2'b00;
  localparam logic [1:0] OpIr     = 2'b01;
  localparam logic [1:0] OpTapRst = 2'b10;

  typedef enum logic [1:0] {StAutoRst, StIdle, StRun} state_e;

  state_e           state_q;
  logic [2:0]       cnt_q;
  logic [1:0]       op_q;
  logic [StepW-1:0] n_q;
  logic [StepW-1:0] step_q;
  logic [MAXW-1:0]  data_q;
  logic [MAXW-1:0]  cap_q;

  function automatic logic [StepW-1:0] eff_len(input logic [LENW-1:0] len);
    if (len == '0) return StepW'(1);
    if (32'(len) > MAXW) return StepW'(MAXW);
    return StepW'(len);
  endfunction

  // First shift cycle: DR has Select/Capture/Shift-entry, IR adds Select-IR in front.
  function automatic logic [StepW-1:0] shift_first(input logic [1:0] op);
    return (op == OpIr) ? StepW'(5) : StepW'(4);
  endfunction

  function automatic logic tms_at(input logic [1:0] op, input logic [StepW-1:0] n,
                                  input logic [StepW-1:0] k);
    logic [StepW-1:0] sf;
    sf = shift_first(op);
    case (op)
      OpDr, OpIr: begin
        if (k < sf - StepW'(2)) return 1'b1;
        if (k < sf) return 1'b0;
        if (k < sf + n) return k == sf + n - StepW'(1);
        return k == sf + n;
      end
      OpTapRst: return k <= StepW'(5);
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [StepW-1:0] last_step(input logic [1:0] op,
                                                 input logic [StepW-1:0] n);
    case (op)
      OpDr:     return n + StepW'(5);
      OpIr:     return n + StepW'(6);
      OpTapRst: return StepW'(6);
      default:  return StepW'(1);
    endcase
  endfunction

  logic [StepW-1:0] sf;
  logic [StepW-1:0] next_k;
  logic             is_scan;
  logic             cur_shift;
  logic             next_shift;
  logic [IdxW-1:0]  cap_idx;

  always_comb begin
    sf         = shift_first(op_q);
    next_k     = step_q + StepW'(1);
    is_scan    = (op_q == OpDr) || (op_q == OpIr);
    cur_shift  = is_scan && (step_q >= sf) && (step_q < sf + n_q);
    next_shift = is_scan && (next_k >= sf) && (next_k < sf + n_q);
    cap_idx    = IdxW'(step_q - sf);
  end

  assign busy = ~cmd_ready;

  always_ff @(posedge TCK) begin
    if (TRST) begin
      state_q   <= StAutoRst;
      cnt_q     <= '0;
      op_q      <= '0;
      n_q       <= '0;
      step_q    <= '0;
      data_q    <= '0;
      cap_q     <= '0;
      TMS       <= 1'b1;
      TDI       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= 1'b0;
      unique case (state_q)
        StAutoRst: begin
          // Five TMS=1 cycles reach Test-Logic-Reset, one TMS=0 lands in Run-Test/Idle.
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == 3'd4) TMS <= 1'b0;
          if (cnt_q == 3'd5) begin
            state_q   <= StIdle;
            cmd_ready <= 1'b1;
            cnt_q     <= '0;
          end
        end
        StIdle: begin
          if (cmd_valid) begin
            state_q   <= StRun;
            cmd_ready <= 1'b0;
            op_q      <= cmd_op;
            n_q       <= eff_len(cmd_len);
            data_q    <= cmd_data;
            cap_q     <= '0;
            step_q    <= StepW'(1);
            TMS       <= tms_at(cmd_op, eff_len(cmd_len), StepW'(1));
            TDI       <= 1'b0;
          end
        end
        StRun: begin
          if (cur_shift) cap_q[cap_idx] <= TDO;
          if (step_q == last_step(op_q, n_q)) begin
            state_q   <= StIdle;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_data  <= cap_q;
            step_q    <= '0;
            TMS       <= 1'b0;
            TDI       <= 1'b0;
          end else begin
            step_q <= next_k;
            TMS    <= tms_at(op_q, n_q, next_k);
            if (next_shift) begin
              TDI    <= data_q[0];
              data_q <= data_q >> 1;
            end else begin
              TDI <= 1'b0;
            end
          end
        end
        default: state_q <= StAutoRst;
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_scan_master.sv
// Directed bench for jtag_scan_master with a behavioural 1149.1 TAP on the pins.
module tb_jtag_scan_master;

  logic        TCK = 1'b0;
  logic        TRST = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [5:0]  cmd_len = '0;
  logic [31:0] cmd_data = '0;
  logic        TMS;
  logic        TDI;
  logic        TDO;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;
  int rsp_cnt  = 0;

  always #5 TCK = ~TCK;

  jtag_scan_master #(.MAXW(32), .LENW(6)) dut (
    .TCK       (TCK),
    .TRST      (TRST),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .cmd_data  (cmd_data),
    .TMS       (TMS),
    .TDI       (TDI),
    .TDO       (TDO),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .busy      (busy)
  );

  // Behavioural TAP: 32-bit DR, 4-bit IR (capture value 4'b0101).
  typedef enum logic [3:0] {
    TapTlr, TapRti, TapSelDr, TapCapDr, TapShDr, TapEx1Dr, TapPauDr, TapEx2Dr, TapUpdDr,
    TapSelIr, TapCapIr, TapShIr, TapEx1Ir, TapPauIr, TapEx2Ir, TapUpdIr
  } tap_e;

  tap_e        tap_st = TapTlr;
  logic [31:0] dr_cap = 32'h0000_003C;
  logic [31:0] tap_dr = '0;
  logic [3:0]  ir_sh  = '0;
  logic [3:0]  tap_ir = '0;

  assign TDO = (tap_st == TapShIr) ? ir_sh[0] : tap_dr[0];

  always @(posedge TCK) begin
    case (tap_st)
      TapTlr:   tap_st <= TMS ? TapTlr   : TapRti;
      TapRti:   tap_st <= TMS ? TapSelDr : TapRti;
      TapSelDr: tap_st <= TMS ? TapSelIr : TapCapDr;
      TapCapDr: tap_st <= TMS ? TapEx1Dr : TapShDr;
      TapShDr:  tap_st <= TMS ? TapEx1Dr : TapShDr;
      TapEx1Dr: tap_st <= TMS ? TapUpdDr : TapPauDr;
      TapPauDr: tap_st <= TMS ? TapEx2Dr : TapPauDr;
      TapEx2Dr: tap_st <= TMS ? TapUpdDr : TapShDr;
      TapUpdDr: tap_st <= TMS ? TapSelDr : TapRti;
      TapSelIr: tap_st <= TMS ? TapTlr   : TapCapIr;
      TapCapIr: tap_st <= TMS ? TapEx1Ir : TapShIr;
      TapShIr:  tap_st <= TMS ? TapEx1Ir : TapShIr;
      TapEx1Ir: tap_st <= TMS ? TapUpdIr : TapPauIr;
      TapPauIr: tap_st <= TMS ? TapEx2Ir : TapPauIr;
      TapEx2Ir: tap_st <= TMS ? TapUpdIr : TapShIr;
      default:  tap_st <= TMS ? TapSelDr : TapRti;
    endcase
    if (tap_st == TapCapDr) tap_dr <= dr_cap;
    if (tap_st == TapShDr)  tap_dr <= {TDI, tap_dr[31:1]};
    if (tap_st == TapCapIr) ir_sh  <= 4'b0101;
    if (tap_st == TapShIr)  ir_sh  <= {TDI, ir_sh[3:1]};
    if (tap_st == TapUpdIr) tap_ir <= ir_sh;
  end

  always @(posedge TCK) if (rsp_valid) rsp_cnt <= rsp_cnt + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Enter at a negedge with TRST low or high; leaves at the negedge of the first ready cycle.
  task automatic do_reset(input string tag);
    logic [63:0] tms_v;
    logic        quiet;
    TRST = 1'b1;
    @(posedge TCK);
    @(negedge TCK);
    check_eq({tag, ".rst_tms"}, 64'(TMS), 64'd1);
    check_eq({tag, ".rst_tdi"}, 64'(TDI), 64'd0);
    check_eq({tag, ".rst_ready"}, 64'(cmd_ready), 64'd0);
    check_eq({tag, ".rst_busy"}, 64'(busy), 64'd1);
    check_eq({tag, ".rst_rsp"}, {31'd0, rsp_valid, rsp_data}, 64'd0);
    @(posedge TCK);
    @(negedge TCK);
    tms_v = '0;
    quiet = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tms_v[c] = TMS;
      if (cmd_ready || rsp_valid) quiet = 1'b0;
      TRST = 1'b0;
      @(negedge TCK);
    end
    check_eq({tag, ".auto_tms"}, tms_v, 64'h1F);
    check_eq({tag, ".auto_quiet"}, 64'(quiet), 64'd1);
    check_eq({tag, ".auto_ready"}, 64'(cmd_ready), 64'd1);
    check_eq({tag, ".auto_tap"}, 64'(tap_st), 64'(TapRti));
  endtask

  // Issue one command from a negedge; returns at the negedge of the rsp_valid cycle.
  task automatic run_cmd(input string tag, input logic [1:0] op, input logic [5:0] len,
                         input logic [31:0] data, output int cycles,
                         output logic [63:0] tms_v, output logic [63:0] tdi_v,
                         output logic [31:0] rsp);
    int guard = 0;
    while (!cmd_ready && guard < 100) begin
      @(negedge TCK);
      guard++;
    end
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    cmd_data  = data;
    @(posedge TCK);
    @(negedge TCK);
    cmd_valid = 1'b0;
    cycles = 0;
    tms_v  = '0;
    tdi_v  = '0;
    while (!rsp_valid && cycles < 60) begin
      tms_v[cycles] = TMS;
      tdi_v[cycles] = TDI;
      cycles++;
      @(negedge TCK);
    end
    rsp = rsp_data;
    check_eq({tag, ".done"}, {62'd0, rsp_valid, cmd_ready}, 64'd3);
  endtask

  int          cyc;
  logic [63:0] tms_v;
  logic [63:0] tdi_v;
  logic [31:0] rsp;

  initial begin
    @(negedge TCK);
    do_reset("init");

    // DR scan, 8 bits.
    dr_cap = 32'h0000_003C;
    run_cmd("dr8", 2'b00, 6'd8, 32'hA5, cyc, tms_v, tdi_v, rsp);
    check_eq("dr8.cycles", 64'(cyc), 64'd13);
    check_eq("dr8.tms", tms_v, 64'hC01);
    check_eq("dr8.tdi", tdi_v, 64'h528);
    check_eq("dr8.rsp", 64'(rsp), 64'h3C);
    check_eq("dr8.tap", 64'(tap_st), 64'(TapRti));

    // IR scan, 4 bits.
    run_cmd("ir4", 2'b01, 6'd4, 32'h6, cyc, tms_v, tdi_v, rsp);
    check_eq("ir4.cycles", 64'(cyc), 64'd10);
    check_eq("ir4.tms", tms_v, 64'h183);
    check_eq("ir4.tdi", tdi_v, 64'h60);
    check_eq("ir4.rsp", 64'(rsp), 64'h5);
    check_eq("ir4.ir", 64'(tap_ir), 64'h6);

    // TAP reset command.
    run_cmd("trst", 2'b10, 6'd9, 32'hFFFF_FFFF, cyc, tms_v, tdi_v, rsp);
    check_eq("trst.cycles", 64'(cyc), 64'd6);
    check_eq("trst.tms", tms_v, 64'h1F);
    check_eq("trst.tdi", tdi_v, 64'h0);
    check_eq("trst.rsp", 64'(rsp), 64'h0);
    check_eq("trst.tap", 64'(tap_st), 64'(TapRti));

    // Reserved op.
    run_cmd("rsvd", 2'b11, 6'd5, 32'hFFFF_FFFF, cyc, tms_v, tdi_v, rsp);
    check_eq("rsvd.cycles", 64'(cyc), 64'd1);
    check_eq("rsvd.tms", tms_v, 64'h0);
    check_eq("rsvd.rsp", 64'(rsp), 64'h0);

    // Length clamp low: len 0 shifts one bit.
    dr_cap = 32'hFFFF_FFF1;
    run_cmd("len0", 2'b00, 6'd0, 32'h1, cyc, tms_v, tdi_v, rsp);
    check_eq("len0.cycles", 64'(cyc), 64'd6);
    check_eq("len0.tms", tms_v, 64'h19);
    check_eq("len0.tdi", tdi_v, 64'h8);
    check_eq("len0.rsp", 64'(rsp), 64'h1);

    // Length clamp high: len 40 shifts 32 bits.
    dr_cap = 32'hDEAD_BEEF;
    run_cmd("len40", 2'b00, 6'd40, 32'h1234_5678, cyc, tms_v, tdi_v, rsp);
    check_eq("len40.cycles", 64'(cyc), 64'd37);
    check_eq("len40.tms", tms_v, 64'hC_0000_0001);
    check_eq("len40.tdi", tdi_v, 64'h9_1A2B_3C0);
    check_eq("len40.rsp", 64'(rsp), 64'hDEAD_BEEF);
    check_eq("len40.dr", 64'(tap_dr), 64'h1234_5678);

    // Response holds while idle.
    repeat (3) @(negedge TCK);
    check_eq("hold.rsp", 64'(rsp_data), 64'hDEAD_BEEF);
    check_eq("hold.valid", 64'(rsp_valid), 64'd0);

    // Back-to-back: cmd_valid held, two 2-bit DR scans.
    begin
      logic [63:0] b2b_tms = '0;
      logic [1:0]  rdy_seen = '0;
      int          rv_first = 0;
      int          rv_second = 0;
      logic [31:0] rsp_first = '0;
      dr_cap    = 32'h0000_0002;
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_len   = 6'd2;
      cmd_data  = 32'h1;
      @(posedge TCK);
      for (int c = 1; c <= 16; c++) begin
        @(negedge TCK);
        if (c <= 15) b2b_tms[c-1] = TMS;
        if (rsp_valid && rv_first == 0) begin
          rv_first  = c;
          rsp_first = rsp_data;
        end else if (rsp_valid && rv_second == 0) begin
          rv_second = c;
        end
        if (c == 8) rdy_seen[0] = cmd_ready;
        if (c == 9) begin
          rdy_seen[1] = cmd_ready;
          cmd_valid   = 1'b0;
        end
      end
      check_eq("b2b.tms", b2b_tms, 64'h3131);
      check_eq("b2b.rv1", 64'(rv_first), 64'd8);
      check_eq("b2b.rv2", 64'(rv_second), 64'd16);
      check_eq("b2b.ready", 64'(rdy_seen), 64'h1);
      check_eq("b2b.rsp1", 64'(rsp_first), 64'h2);
      check_eq("b2b.rsp2", 64'(rsp_data), 64'h2);
    end

    // Abort a 16-bit DR scan during shift bit 3.
    begin
      int rsp_before;
      @(negedge TCK);
      cmd_valid = 1'b1;
      cmd_op    = 2'b00;
      cmd_len   = 6'd16;
      cmd_data  = 32'hBEEF;
      @(posedge TCK);
      @(negedge TCK);
      cmd_valid = 1'b0;
      repeat (6) @(negedge TCK);
      check_eq("abort.bit3_tms", 64'(TMS), 64'd0);
      check_eq("abort.bit3_tdi", 64'(TDI), 64'd1);
      rsp_before = rsp_cnt;
      TRST = 1'b1;
      @(negedge TCK);
      check_eq("abort.tms", 64'(TMS), 64'd1);
      check_eq("abort.ready", 64'(cmd_ready), 64'd0);
      do_reset("abort");
      check_eq("abort.no_rsp", 64'(rsp_cnt), 64'(rsp_before));
    end

    dr_cap = 32'h0000_003C;
    run_cmd("post", 2'b00, 6'd8, 32'hA5, cyc, tms_v, tdi_v, rsp);
    check_eq("post.cycles", 64'(cyc), 64'd13);
    check_eq("post.tms", tms_v, 64'hC01);
    check_eq("post.rsp", 64'(rsp), 64'h3C);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/jtag_scan_master.md
Name: jtag_scan_master

Overview:
- Host-side driver for the team's IEEE 1149.1 TAP controller.
- Accepts IR-scan, DR-scan and TAP-reset commands, generates the TMS/TDI bit sequence that walks the TAP state machine, and collects TDO into a response word.
- Sits between the test-access command logic and the TAP pins.
- Clocked by TCK. Tracks the target TAP state internally and always leaves the TAP in Run-Test/Idle between commands.

Parameters:
- MAXW, 32, maximum scan length in bits; width of cmd_data and rsp_data.
- LENW, 6, width of cmd_len. Must satisfy 2^LENW > MAXW.

Ports:
- TCK  in  1  scan clock; all state updates on its rising edge.
- TRST  in  1  synchronous, active-high reset of this block.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  2  00 = DR scan, 01 = IR scan, 10 = TAP reset, 11 = reserved.
- cmd_len  in  LENW  number of bits to shift.
- cmd_data  in  MAXW  TDI data, shifted LSB first.
- TMS  out  1  registered test mode select to the TAP.
- TDI  out  1  registered test data to the TAP.
- TDO  in  1  test data from the TAP.
- rsp_valid  out  1  one-cycle pulse: scan finished.
- rsp_data  out  MAXW  captured TDO bits, LSB first.
- busy  out  1  high whenever cmd_ready is low.

Behaviour:
- Reset values while TRST=1:
  - TMS=1, TDI=0
  - cmd_ready=0, busy=1
  - rsp_valid=0, rsp_data=0
  - all counters 0
- TRST has priority over all other inputs. TRST asserted mid-command aborts the command; no rsp_valid is produced.
- Auto-reset after TRST deasserts:
  - Drive TMS=1 for 5 cycles, then TMS=0 for 1 cycle. This leaves the TAP in Run-Test/Idle.
  - cmd_ready=1 from the following cycle.
- IDLE state: TMS=0, TDI=0, cmd_ready=1.
- Handshake:
  - A command is accepted on the rising edge where cmd_valid=1 and cmd_ready=1.
  - cmd_op, cmd_len and cmd_data are latched at that edge.
  - cmd_ready=0 from the next cycle until the command completes.
- Length rule for scans (DR/IR): effective length n.
  - cmd_len=0 → n=1.
  - cmd_len>MAXW → n=MAXW.
  - otherwise n=cmd_len.
- TMS/TDI timing: each value is driven for exactly one cycle. The TAP samples it on the next TCK rising edge.
- Drive cycles are numbered 1.. starting the cycle after acceptance.
- DR scan, n+5 drive cycles:
  - TMS sequence: 1 (Select-DR), 0 (Capture), 0 (Shift).
  - Then n shift cycles with TDI=data[i] and TMS=0, except TMS=1 on bit n-1 (Exit1).
  - Then 1 (Update), 0 (Run-Test/Idle).
- IR scan, n+6 drive cycles: same as DR scan, but prefixed with an extra TMS=1 (Select-DR → Select-IR).
- TDI=0 on every non-shift cycle.
- TDO capture:
  - rsp_data[i] = TDO sampled on the rising edge that ends the drive cycle carrying TDI=data[i].
  - rsp_data bits ≥ n are 0.
- TAP reset command: 6 drive cycles, TMS=1,1,1,1,1,0. rsp_data=0.
- Reserved op (11): no TAP activity; one drive cycle of TMS=0; rsp_data=0.
- Completion:
  - rsp_valid=1 and cmd_ready=1 together in the first IDLE cycle after the last drive cycle.
  - rsp_data is loaded at that time and holds until the next completion.
- Back-to-back: a new command may be accepted in the same cycle as rsp_valid. Its drive cycle 1 follows immediately, with no extra idle gap.
- cmd_valid while busy is ignored; the block does not queue commands.

Test Plan:
- Reset: TRST=1 for 2 cycles, then 0 → TMS=1,1,1,1,1,0, then cmd_ready=1 in cycle 7; rsp_valid stays 0.
- DR scan: op=00, len=8, data=0xA5; bench TAP model captures 0x3C.
  - TMS=1,0,0,0,0,0,0,0,0,0,1,1,0
  - TDI during shift = 1,0,1,0,0,1,0,1
  - rsp_valid 14 cycles after accept, rsp_data=0x0000003C.
- IR scan: op=01, len=4, data=0x6.
  - TMS=1,1,0,0,0,0,0,1,1,0
  - TDI shift = 0,1,1,0
  - TAP model IR register = 0x6 after Update-IR.
- Back-to-back: cmd_valid held high with two DR commands (len 2) → second accepted on the rsp_valid cycle of the first; TMS never idles between them.
- Clamping: len=0 data=1 → one shift bit, TMS=1,0,0,1,1,0. len=40 → exactly 32 shift cycles.
- Abort: TRST=1 during shift bit 3 of a 16-bit DR scan → TMS=1 next cycle; no rsp_valid; full auto-reset sequence after release; then a new scan completes correctly.
